// File: rtl/mips_wb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_wb_pkg
// Description : Shared widths and the writeback request type used by the
//               writeback merge stage and its long-latency result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_wb_pkg;

  localparam int DW   = 32;       // register write data width
  localparam int AW   = 5;        // register address width
  localparam int NREG = 1 << AW;  // architectural registers tracked by the scoreboard

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Small synchronous FIFO of writeback requests. Pushes while
//               full and pops while empty are ignored. Head is the oldest
//               entry and is valid whenever empty=0.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_req_t       mem_q [DEPTH];
  wb_req_t       mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Next-state: storage write, pointer advance (wraps naturally, DEPTH is 2^n), occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the queue and discards stored entries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_merge.sv
`default_nettype none
// ============================================================================
// Module      : wb_merge
// Description : Writeback merge stage driving the single register-file write
//               port. Pipeline WB results win; buffered long-latency results
//               fill the idle slots. Tracks outstanding long-latency
//               destinations for decode interlock and raises wb_hold to force
//               a free slot when the FIFO is full or has waited too long.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_merge
  import mips_wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_wa,
  input  logic [DW-1:0] pipe_wd,
  input  logic          ll_valid,
  output logic          ll_ready,
  input  logic [AW-1:0] ll_wa,
  input  logic [DW-1:0] ll_wd,
  input  logic          issue_v,
  input  logic [AW-1:0] issue_wa,
  input  logic [AW-1:0] chk_ra1,
  input  logic [AW-1:0] chk_ra2,
  output logic          busy1,
  output logic          busy2,
  output logic          wb_hold,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd
);

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX - 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

  logic            pipe_valid;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  wb_req_t         fifo_head;
  wb_req_t         ll_req;

  logic [NREG-1:0] pending_q, pending_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            wb_hold_q, wb_hold_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_wa_q, rf_wa_d;
  logic [DW-1:0]   rf_wd_q, rf_wd_d;

  // A pipe write to r0 is a no-op, so it must not steal the slot from the FIFO
  assign pipe_valid = pipe_we && (pipe_wa != '0);
  // r0 results are acknowledged but never queued
  assign fifo_push  = ll_valid && ll_ready && (ll_wa != '0);
  assign fifo_pop   = !fifo_empty && !pipe_valid;
  assign ll_ready   = !fifo_full;
  assign ll_req     = '{wa: ll_wa, wd: ll_wd};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (ll_req),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Write-port arbitration, scoreboard update, starvation tracking and hold request
  always_comb begin
    rf_we_d   = 1'b0;
    rf_wa_d   = rf_wa_q;
    rf_wd_d   = rf_wd_q;
    pending_d = pending_q;
    starve_d  = starve_q;

    if (pipe_valid) begin
      rf_we_d = 1'b1;
      rf_wa_d = pipe_wa;
      rf_wd_d = pipe_wd;
    end else if (fifo_pop) begin
      rf_we_d = 1'b1;
      rf_wa_d = fifo_head.wa;
      rf_wd_d = fifo_head.wd;
      pending_d[fifo_head.wa] = 1'b0;
    end

    // Applied after the clear so a same-index issue keeps the register busy
    if (issue_v && (issue_wa != '0)) begin
      pending_d[issue_wa] = 1'b1;
    end

    if (fifo_pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != STARVE_SAT) begin
      starve_d = starve_q + SW'(1);
    end

    wb_hold_d = fifo_full || (!fifo_empty && !fifo_pop && (starve_q == STARVE_LIM));
  end

  // Output and scoreboard registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q   <= 1'b0;
      rf_wa_q   <= '0;
      rf_wd_q   <= '0;
      pending_q <= '0;
      starve_q  <= '0;
      wb_hold_q <= 1'b0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_wa_q   <= rf_wa_d;
      rf_wd_q   <= rf_wd_d;
      pending_q <= pending_d;
      starve_q  <= starve_d;
      wb_hold_q <= wb_hold_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_wa   = rf_wa_q;
  assign rf_wd   = rf_wd_q;
  assign wb_hold = wb_hold_q;
  assign busy1   = (chk_ra1 != '0) && pending_q[chk_ra1];
  assign busy2   = (chk_ra2 != '0) && pending_q[chk_ra2];

  // Re-issuing to an outstanding destination is illegal unless its result retires this cycle
  a_no_double_issue : assert property (@(posedge clk) disable iff (!rst)
    (issue_v && (issue_wa != '0)) |->
      (!pending_q[issue_wa] || (fifo_pop && (fifo_head.wa == issue_wa))));

  // Upstream must leave the slot free in the cycle after a hold request
  a_hold_frees_slot : assert property (@(posedge clk) disable iff (!rst)
    wb_hold_q |-> !pipe_we);

endmodule
`default_nettype wire

// File: tb/tb_wb_merge.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_merge
// Description : Directed bench for wb_merge with a queue-based reference model
//               checked every cycle plus hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_merge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_wa = '0;
  logic [31:0] pipe_wd = '0;
  logic        ll_valid = 1'b0;
  logic [4:0]  ll_wa = '0;
  logic [31:0] ll_wd = '0;
  logic        issue_v = 1'b0;
  logic [4:0]  issue_wa = '0;
  logic [4:0]  chk_ra1 = '0;
  logic [4:0]  chk_ra2 = '0;
  logic        ll_ready, busy1, busy2, wb_hold, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int total = 0;
  int bad   = 0;

  wb_merge #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_wa(ll_wa), .ll_wd(ll_wd),
    .issue_v(issue_v), .issue_wa(issue_wa),
    .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .busy1(busy1), .busy2(busy2),
    .wb_hold(wb_hold), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] wa; logic [31:0] wd; } ent_t;
  ent_t        q[$];
  ent_t        h;
  bit          m_pend [32];
  int          m_starve = 0;
  bit          m_hold = 0, m_we = 0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  bit          m_pv, m_pop, m_wasfull, m_wasempty;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      q.delete();
      foreach (m_pend[i]) m_pend[i] = 0;
      m_starve = 0; m_hold = 0; m_we = 0; m_wa = '0; m_wd = '0;
    end else begin
      m_pv       = pipe_we && (pipe_wa != 0);
      m_wasempty = (q.size() == 0);
      m_wasfull  = (q.size() == 4);
      m_pop      = !m_wasempty && !m_pv;
      // hold after 8 cycles in a row unserved, or whenever the buffer was full
      m_hold     = m_wasfull || (!m_wasempty && !m_pop && (m_starve + 1 >= 8));
      if (m_pv) begin
        m_we = 1; m_wa = pipe_wa; m_wd = pipe_wd;
      end else if (m_pop) begin
        h = q.pop_front();
        m_we = 1; m_wa = h.wa; m_wd = h.wd;
        m_pend[h.wa] = 0;
      end else begin
        m_we = 0;
      end
      if (ll_valid && !m_wasfull && (ll_wa != 0)) q.push_back('{ll_wa, ll_wd});
      if (issue_v && (issue_wa != 0)) m_pend[issue_wa] = 1;
      m_starve = (m_pop || m_wasempty) ? 0 : m_starve + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("rf_we", rf_we, m_we);
    chk("rf_wa", rf_wa, m_wa);
    chk("rf_wd", rf_wd, m_wd);
    chk("wb_hold", wb_hold, m_hold);
    chk("ll_ready", ll_ready, q.size() < 4);
    chk("busy1", busy1, (chk_ra1 != 0) && m_pend[chk_ra1]);
    chk("busy2", busy2, (chk_ra2 != 0) && m_pend[chk_ra2]);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    if (m_hold) pipe_we = 1'b0;  // upstream honours the hold request
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    pipe_we = 0; ll_valid = 0; issue_v = 0;
  endtask

  initial begin
    repeat (2) tick();
    chk("reset rf_we", rf_we, 0);
    chk("reset rf_wa", rf_wa, 0);
    chk("reset wb_hold", wb_hold, 0);
    chk("reset ll_ready", ll_ready, 1);
    rst = 1;
    repeat (2) tick();

    // priority: pipe beats long-latency result in the same cycle
    pipe_we = 1; pipe_wa = 3; pipe_wd = 32'hAA;
    ll_valid = 1; ll_wa = 5; ll_wd = 32'hBB;
    issue_v = 1; issue_wa = 5; chk_ra1 = 5;
    tick();
    chk("prio c1 wa", rf_wa, 3);
    chk("prio c1 wd", rf_wd, 32'hAA);
    chk("prio c1 busy5", busy1, 1);
    idle();
    tick();
    chk("prio c2 we", rf_we, 1);
    chk("prio c2 wa", rf_wa, 5);
    chk("prio c2 wd", rf_wd, 32'hBB);
    chk("prio c2 busy5", busy1, 0);
    tick();
    chk("prio c3 we", rf_we, 0);

    // r0 pipe write does not block the FIFO
    ll_valid = 1; ll_wa = 7; ll_wd = 32'h77; issue_v = 1; issue_wa = 7;
    tick();
    idle();
    pipe_we = 1; pipe_wa = 0; pipe_wd = 32'hDEAD;
    tick();
    chk("r0 pop wa", rf_wa, 7);
    chk("r0 pop wd", rf_wd, 32'h77);
    idle();
    tick();

    // full: four pushes under continuous pipe traffic
    for (int i = 0; i < 4; i++) begin
      pipe_we = 1; pipe_wa = 1; pipe_wd = 32'h1000 + i;
      ll_valid = 1; ll_wa = 5'(10 + i); ll_wd = 32'hA0 + i;
      issue_v = 1; issue_wa = 5'(10 + i);
      tick();
    end
    chk("full ready", ll_ready, 0);
    chk("full hold early", wb_hold, 0);
    issue_v = 0; ll_wa = 14; ll_wd = 32'hEE; pipe_wd = 32'h1004;
    tick();
    chk("full hold", wb_hold, 1);
    chk("full pipe wa", rf_wa, 1);
    pipe_we = 1; pipe_wd = 32'h1005;
    tick();
    chk("full pop wa", rf_wa, 10);
    chk("full pop wd", rf_wd, 32'hA0);
    chk("full ready after pop", ll_ready, 1);
    ll_valid = 0; pipe_we = 1;
    tick();
    chk("full pop2 wa", rf_wa, 11);
    idle();
    repeat (4) tick();

    // starvation: one queued entry behind endless pipe writes
    ll_valid = 1; ll_wa = 20; ll_wd = 32'h2020; issue_v = 1; issue_wa = 20;
    pipe_we = 1; pipe_wa = 2; pipe_wd = 32'h100;
    tick();
    ll_valid = 0; issue_v = 0;
    for (int i = 0; i < 8; i++) begin
      pipe_we = 1; pipe_wd = 32'h101 + i;
      tick();
      if (i == 6) chk("starve hold low", wb_hold, 0);
    end
    chk("starve hold", wb_hold, 1);
    pipe_we = 1; pipe_wd = 32'h1FF;
    tick();
    chk("starve pop wa", rf_wa, 20);
    chk("starve pop wd", rf_wd, 32'h2020);
    chk("starve hold drop", wb_hold, 0);
    idle();
    repeat (2) tick();

    // scoreboard: busy until written, re-issue in the clear cycle keeps it busy
    issue_v = 1; issue_wa = 9; chk_ra1 = 9; chk_ra2 = 0;
    tick();
    chk("sb busy1", busy1, 1);
    chk("sb busy2 r0", busy2, 0);
    issue_v = 0; chk_ra2 = 9;
    tick();
    ll_valid = 1; ll_wa = 9; ll_wd = 32'h99;
    tick();
    chk("sb queued busy", busy1, 1);
    ll_valid = 0; issue_v = 1; issue_wa = 9;
    tick();
    chk("sb clear wa", rf_wa, 9);
    chk("sb reissue busy", busy1, 1);
    issue_v = 0; ll_valid = 1; ll_wa = 9; ll_wd = 32'h9A;
    tick();
    ll_valid = 0;
    tick();
    chk("sb final wd", rf_wd, 32'h9A);
    chk("sb final busy", busy2, 0);
    tick();

    // asynchronous reset with three results queued
    for (int i = 0; i < 3; i++) begin
      pipe_we = 1; pipe_wa = 4; pipe_wd = 32'h400 + i;
      ll_valid = 1; ll_wa = 5'(21 + i); ll_wd = 32'h2100 + i;
      issue_v = 1; issue_wa = 5'(21 + i);
      tick();
    end
    chk_ra1 = 21; chk_ra2 = 23;
    #1;
    chk("pre-reset busy", busy1, 1);
    rst = 0;
    #1;
    chk("arst rf_we", rf_we, 0);
    chk("arst busy1", busy1, 0);
    chk("arst busy2", busy2, 0);
    chk("arst ready", ll_ready, 1);
    idle();
    repeat (2) tick();
    rst = 1;
    repeat (3) tick();
    chk("post-reset no write", rf_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
